// File: rtl/spm_arbiter.sv
// Round-robin arbiter sharing one serial-parallel multiplier among NREQ requesters.
// Optional RUN-state watchdog enabled by defining SPM_ARB_TIMEOUT_EN.
module spm_arbiter #(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 2*WIDTH+8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]    rsp_prod,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  spm_start,
    output logic [WIDTH-1:0]      spm_mc,
    output logic [WIDTH-1:0]      spm_mp,
    input  logic                  spm_done,
    input  logic [2*WIDTH-1:0]    spm_prod
);

    localparam int IW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [IW-1:0]      last_q, last_d;
    logic [WIDTH-1:0]   mc_q, mc_d, mp_q, mp_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [IW-1:0]      win_idx, cand;
    logic               found;

`ifdef SPM_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT;
`endif

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found   = 1'b0;
        win_idx = last_q;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IW'((int'(last_q) + i) % NREQ);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        prod_d  = prod_q;
`ifdef SPM_ARB_TIMEOUT_EN
        tmo_d   = tmo_q;
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_RUN;
                    last_d  = win_idx;
                    mc_d    = a_in[int'(win_idx)*WIDTH +: WIDTH];
                    mp_d    = b_in[int'(win_idx)*WIDTH +: WIDTH];
`ifdef SPM_ARB_TIMEOUT_EN
                    tmo_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            S_RUN: begin
                if (spm_done) begin
                    prod_d  = spm_prod;
                    state_d = S_RESP;
`ifdef SPM_ARB_TIMEOUT_EN
                    err_d   = 1'b0;
                end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                    prod_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    tmo_d   = tmo_q + TW'(1);
`endif
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            last_q  <= IW'(NREQ - 1);
            mc_q    <= '0;
            mp_q    <= '0;
            prod_q  <= '0;
`ifdef SPM_ARB_TIMEOUT_EN
            tmo_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
            prod_q  <= prod_d;
`ifdef SPM_ARB_TIMEOUT_EN
            tmo_q   <= tmo_d;
            err_q   <= err_d;
`endif
        end
    end

    // Grant is combinational from req, so it is gated by rst to stay quiet during reset.
    assign gnt       = (state_q == S_IDLE && found && !rst) ? (NREQ'(1) << win_idx) : '0;
    assign rsp_valid = (state_q == S_RESP) ? (NREQ'(1) << last_q) : '0;
    assign rsp_prod  = prod_q;
    assign busy      = (state_q != S_IDLE);
    assign spm_start = (state_q == S_RUN);
    assign spm_mc    = mc_q;
    assign spm_mp    = mp_q;
`ifdef SPM_ARB_TIMEOUT_EN
    assign rsp_err   = (state_q == S_RESP) && err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_spm_arbiter.sv
// Directed bench for spm_arbiter with a behavioural multiplier model and
// a scoreboard monitor that checks grants and responses as they appear.
module tb_spm_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a_in, b_in;
    logic [N-1:0]   gnt, rsp_valid;
    logic [2*W-1:0] rsp_prod, spm_prod;
    logic           rsp_err, busy, spm_start, spm_done;
    logic [W-1:0]   spm_mc, spm_mp;

    spm_arbiter #(.WIDTH(W), .NREQ(N), .TIMEOUT(72)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_prod(rsp_prod), .rsp_err(rsp_err),
        .busy(busy), .spm_start(spm_start), .spm_mc(spm_mc), .spm_mp(spm_mp),
        .spm_done(spm_done), .spm_prod(spm_prod)
    );

    always #5 clk = ~clk;

    // Multiplier model: done rises mul_lat cycles after start goes high.
    int   mul_lat  = 34;
    logic mul_hang = 1'b0;
    int   mcnt     = 0;
    always @(posedge clk) begin
        if (!spm_start) mcnt <= 0;
        else if (mcnt < mul_lat) mcnt <= mcnt + 1;
    end
    assign spm_done = spm_start && !mul_hang && (mcnt == mul_lat);
    assign spm_prod = spm_done ? ({32'b0, spm_mc} * {32'b0, spm_mp}) : 64'hDEAD_BEEF_DEAD_BEEF;

    typedef struct {
        int          idx;
        logic [63:0] prod;
        logic        err;
        int          lat;
    } rsp_t;

    int   exp_gnt[$];
    rsp_t exp_rsp[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   last_gcyc = 0;
    int   low_cnt = 100;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_job(input int idx, input logic [63:0] prod, input logic err, input int lat);
        rsp_t e;
        e.idx = idx; e.prod = prod; e.err = err; e.lat = lat;
        exp_gnt.push_back(idx);
        exp_rsp.push_back(e);
    endtask

    task automatic set_ops(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
        a_in[idx*W +: W] = a;
        b_in[idx*W +: W] = b;
    endtask

    task automatic wait_gnt(input int idx, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (gnt[idx]) break;
        end
        if (k == budget) chk("gnt_wait_timeout", 64'(idx), 64'hFF);
        @(posedge clk); #1;
        req[idx] = 1'b0;
    endtask

    task automatic wait_rsp(input int idx, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (rsp_valid[idx]) break;
        end
        if (k == budget) chk("rsp_wait_timeout", 64'(idx), 64'hFF);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (gnt !== '0) begin
            if (exp_gnt.size() == 0) chk("gnt_unexpected", 64'(gnt), 64'h0);
            else chk("gnt", 64'(gnt), 64'(4'b0001 << exp_gnt.pop_front()));
            last_gcyc = cyc;
        end
        if (rsp_valid !== '0) begin
            if (exp_rsp.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'h0);
            else begin
                rsp_t e;
                e = exp_rsp.pop_front();
                chk("rsp_valid", 64'(rsp_valid), 64'(4'b0001 << e.idx));
                chk("rsp_prod", rsp_prod, e.prod);
                chk("rsp_err", 64'(rsp_err), 64'(e.err));
                chk("latency", 64'(cyc - last_gcyc), 64'(e.lat));
            end
        end else if (rsp_err !== 1'b0) begin
            chk("rsp_err_stray", 64'(rsp_err), 64'h0);
        end
        if (spm_start === 1'b1) begin
            if (low_cnt > 0) chk("start_gap_ok", 64'(low_cnt >= 2), 64'h1);
            low_cnt = 0;
        end else begin
            low_cnt++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ng;
        rst = 1'b1; req = '0; a_in = '0; b_in = '0;
        set_ops(0, 2, 10); set_ops(1, 3, 20); set_ops(2, 4, 30); set_ops(3, 5, 40);
        req = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 64'(gnt), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_start", 64'(spm_start), 64'h0);
        chk("rst_mc", 64'(spm_mc), 64'h0);
        chk("rst_prod", rsp_prod, 64'h0);

        // Contention: all four held, grants rotate 0,1,2,3,0
        mul_lat = 5;
        push_job(0, 20, 0, 7); push_job(1, 60, 0, 7); push_job(2, 120, 0, 7);
        push_job(3, 200, 0, 7); push_job(0, 20, 0, 7);
        rst = 1'b0;
        ng = 0;
        for (int k = 0; k < 500 && ng < 5; k++) begin
            @(negedge clk);
            if (gnt != '0) ng++;
        end
        chk("contention_grants", 64'(ng), 64'd5);
        @(posedge clk); #1;
        req = '0;
        wait_rsp(0, 100);

        // Single requester, 3*5
        @(posedge clk); #1;
        mul_lat = 34;
        set_ops(0, 3, 5);
        push_job(0, 15, 0, 36);
        req[0] = 1'b1;
        wait_gnt(0, 50);
        wait_rsp(0, 100);

        // Mid-job arrival: req[2] rises while requester 1 runs
        @(posedge clk); #1;
        set_ops(1, 7, 9);
        push_job(1, 63, 0, 36);
        push_job(2, 143, 0, 36);
        req[1] = 1'b1;
        wait_gnt(1, 50);
        repeat (3) @(posedge clk);
        #1;
        set_ops(2, 11, 13);
        req[2] = 1'b1;
        wait_rsp(1, 100);
        @(negedge clk);
        chk("midjob_gnt_after_resp", 64'(gnt), 64'h4);
        @(posedge clk); #1;
        set_ops(2, 32'h1234, 32'h5678);
        req[2] = 1'b0;
        wait_rsp(2, 100);

        // Reset in RUN: job for requester 1 aborted, then 0011 goes to 0 first
        @(posedge clk); #1;
        exp_gnt.push_back(1);
        req[1] = 1'b1;
        wait_gnt(1, 50);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rrun_busy", 64'(busy), 64'h0);
        chk("rrun_start", 64'(spm_start), 64'h0);
        chk("rrun_mc", 64'(spm_mc), 64'h0);
        chk("rrun_mp", 64'(spm_mp), 64'h0);
        chk("rrun_prod", rsp_prod, 64'h0);
        chk("rrun_rsp_valid", 64'(rsp_valid), 64'h0);
        req = 4'b0011;
        chk("rrun_gnt", 64'(gnt), 64'h0);
        push_job(0, 15, 0, 36);
        push_job(1, 63, 0, 36);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_gnt(0, 50);
        wait_gnt(1, 100);
        wait_rsp(1, 100);

        // Max operands
        @(posedge clk); #1;
        set_ops(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        push_job(3, 64'hFFFF_FFFE_0000_0001, 0, 36);
        req[3] = 1'b1;
        wait_gnt(3, 50);
        wait_rsp(3, 100);

`ifdef SPM_ARB_TIMEOUT_EN
        // Multiplier never finishes: watchdog forces an error response
        @(posedge clk); #1;
        mul_hang = 1'b1;
        push_job(0, 0, 1, 73);
        req[0] = 1'b1;
        wait_gnt(0, 50);
        wait_rsp(0, 200);
        // Done on the expiry cycle wins
        @(posedge clk); #1;
        mul_hang = 1'b0;
        mul_lat = 71;
        push_job(0, 15, 0, 73);
        req[0] = 1'b1;
        wait_gnt(0, 50);
        wait_rsp(0, 200);
`else
        // Without the watchdog RUN waits indefinitely
        @(posedge clk); #1;
        mul_hang = 1'b1;
        exp_gnt.push_back(0);
        req[0] = 1'b1;
        wait_gnt(0, 50);
        repeat (100) @(posedge clk);
        #1;
        chk("hang_busy", 64'(busy), 64'h1);
        chk("hang_start", 64'(spm_start), 64'h1);
        rst = 1'b1;
        #1;
        chk("hang_rst_busy", 64'(busy), 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        mul_hang = 1'b0;
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("gnt_queue_empty", 64'(exp_gnt.size()), 64'h0);
        chk("rsp_queue_empty", 64'(exp_rsp.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
